servant_mtimer: RTL and testbench
=================================

Name: servant_mtimer

Overview:
- Memory-mapped RISC-V machine timer: 64-bit free-running mtime, 64-bit mtimecmp, registered o_mtip.
- o_mtip drives the i_mtip input of the core CSR stage, which masks it with mstatus.MIE/mie.MTIE and raises the timer interrupt (mcause 7).
- Sits on the servant Wishbone data bus as a 16-byte slave.
- Counting freezes while the hart is halted in debug mode, so single-step and halt do not generate spurious timer interrupts.

Parameters:
- DIV, 1, prescale ratio: mtime increments once every DIV clocks. Legal range 1..65535; DIV=1 means every clock.
- DBG_STOP, 1, when 1, counting is frozen while i_dbg_halt=1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_dbg_halt  in  1  hart halted in debug mode (same signal as the CSR stage's debug halt)
- i_wb_cyc  in  1  bus request
- i_wb_we  in  1  1 = write
- i_wb_adr  in  2  word select, byte address bits [3:2]: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte enables
- o_wb_rdt  out  32  read data
- o_wb_ack  out  1  transfer acknowledge
- o_mtip  out  1  timer interrupt pending, level

Behaviour:
Reset (i_rst_n=0, asynchronous):
- mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, hi_shadow=0.
- o_wb_ack=0, o_wb_rdt=0, o_mtip=0.
- Reset mid-transfer drops the ack; the master retries.

Prescaler:
- Counter of width clog2(DIV), minimum 1 bit.
- tick=1 when count==DIV-1 and not frozen; the counter then wraps to 0.
- frozen = DBG_STOP & i_dbg_halt. While frozen, both prescaler and mtime hold.
- DIV=1: tick = !frozen.

mtime:
- On tick, mtime <= mtime+1, full 64-bit carry.
- Wraps from all-ones to 0 with no flag.

Bus handshake:
- ack is a 1-cycle pulse: o_wb_ack <= i_wb_cyc & !o_wb_ack.
- Hence 1-cycle latency, and every second cycle at most under continuous cyc.
- Reads and writes take effect in the same cycle the ack is registered.
- o_wb_rdt is registered alongside the ack and is valid only while ack=1. It holds its value otherwise.

Writes (i_wb_cyc & i_wb_we & !o_wb_ack):
- Byte-wise merge per i_wb_sel into the addressed 32-bit half.
- A write to either mtime half takes priority over a same-cycle tick. The written half gets the written value and the tick is discarded for that cycle; the prescaler still advances normally.
- A write to mtime resets neither the prescaler nor hi_shadow.

Reads (i_wb_cyc & !i_wb_we & !o_wb_ack):
- adr 0 returns mtime[31:0] and captures mtime[63:32] into hi_shadow in the same cycle.
- adr 1 returns hi_shadow, not live mtime[63:32]. This makes a lo-then-hi read sequence atomic across a carry.
- adr 2 and adr 3 return the live mtimecmp halves.

Compare:
- o_mtip <= (mtime >= mtimecmp), registered and unsigned 64-bit.
- o_mtip asserts 1 clock after the condition first holds.
- o_mtip deasserts 1 clock after a mtimecmp write makes the condition false.
- Level output, never latched; software clears it only by writing mtimecmp.
- Half-updated mtimecmp glitches are the software's responsibility (spec-standard write sequence).
- Compare continues while frozen; the frozen mtime is still compared.

Decomposition:
- Shared package servant_pkg holds:
  - address constants MTIMER_MTIME_LO=2'd0, MTIMER_MTIME_HI=2'd1, MTIMER_CMP_LO=2'd2, MTIMER_CMP_HI=2'd3
  - reset constant MTIMECMP_RST=64'hFFFF_FFFF_FFFF_FFFF
  - a byte-merge function, merge32(old, new, sel)
- One sub-module is natural: servant_mtimer_prescale, containing the DIV counter plus the freeze gate and producing tick. The 64-bit counter, bus decode and compare stay in the top.

Test Plan:
1. Reset/default: hold i_rst_n low, release, run 100 clks with DIV=1 and no bus activity -> o_mtip=0; a read of adr 0 returns the elapsed count; a read of adr 3 returns 32'hFFFF_FFFF.
2. Interrupt assert and clear: write cmp_hi=0, then cmp_lo=50 with DIV=1 -> o_mtip rises exactly 1 clk after mtime reaches 50; writing cmp_lo=32'hFFFF_FFFF while cmp_hi=0 -> o_mtip falls 1 clk after the write ack.
3. Atomic carry read: write mtime_hi=0, then mtime_lo=32'hFFFF_FFFE; read lo, then hi -> the hi value equals hi_shadow captured at the lo read (0 if the lo value ≥ FFFF_FFFE, else consistent); there is never a lo=FFFF_FFFF paired with hi=1.
4. Prescale: DIV=4; measure over 40 clks -> mtime advanced by exactly 10; the first increment occurs 4 clks after reset release.
5. Debug freeze: DIV=1, DBG_STOP=1, pulse i_dbg_halt high for 20 clks -> mtime advances 20 less than the clock count; with DBG_STOP=0 -> no difference.
6. Write/tick collision and byte enables: write mtime_lo=32'h1234_5678 with sel=4'b0011 in a tick cycle -> lo[15:0]=16'h5678 with upper bytes unchanged and no +1 applied; ack is high for 1 cycle only, and continuous i_wb_cyc yields an alternating ack.

Source files
------------

// File: rtl/servant_pkg.sv
// Shared constants and helpers for the servant SoC peripherals.
package servant_pkg;

  localparam logic [1:0]  MTIMER_MTIME_LO = 2'd0;
  localparam logic [1:0]  MTIMER_MTIME_HI = 2'd1;
  localparam logic [1:0]  MTIMER_CMP_LO   = 2'd2;
  localparam logic [1:0]  MTIMER_CMP_HI   = 2'd3;

  localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

  // Byte-enable merge of a 32-bit write into an existing word.
  function automatic logic [31:0] merge32(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/servant_mtimer_if.sv
// Wishbone data-bus slice used by the machine timer.
interface servant_mtimer_if;
  logic        cyc;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] rdt;
  logic        ack;

  modport master (output cyc, we, adr, dat, sel, input  rdt, ack);
  modport slave  (input  cyc, we, adr, dat, sel, output rdt, ack);
endinterface

// File: rtl/servant_mtimer_prescale.sv
// DIV prescaler with debug-halt freeze; produces the mtime increment tick.
module servant_mtimer_prescale #(
  parameter int unsigned DIV      = 1,
  parameter bit          DBG_STOP = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_dbg_halt,
  output logic o_tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          frozen;

  assign frozen = DBG_STOP & i_dbg_halt;
  // With DIV=1 LAST is 0 and cnt never leaves 0, so tick is simply !frozen.
  assign o_tick = !frozen && (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)    cnt <= '0;
    else if (!frozen) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/servant_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a 16-byte Wishbone slave.
module servant_mtimer
  import servant_pkg::*;
#(
  parameter int unsigned DIV      = 1,
  parameter bit          DBG_STOP = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dbg_halt,
  servant_mtimer_if.slave   wb,
  output logic              o_mtip
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow;
  logic [31:0] rdt_q;
  logic        ack_q;
  logic        tick;
  logic        acc, wr, rd;

  servant_mtimer_prescale #(.DIV(DIV), .DBG_STOP(DBG_STOP)) u_prescale (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_dbg_halt (i_dbg_halt),
    .o_tick     (tick)
  );

  assign acc    = wb.cyc & !ack_q;
  assign wr     = acc &  wb.we;
  assign rd     = acc & !wb.we;
  assign wb.ack = ack_q;
  assign wb.rdt = rdt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RST;
      hi_shadow <= '0;
      ack_q     <= 1'b0;
      rdt_q     <= '0;
      o_mtip    <= 1'b0;
    end else begin
      ack_q  <= wb.cyc & !ack_q;
      o_mtip <= (mtime >= mtimecmp);

      // A bus write to either half wins over the tick for this cycle.
      if (wr && wb.adr == MTIMER_MTIME_LO)
        mtime[31:0]  <= merge32(mtime[31:0], wb.dat, wb.sel);
      else if (wr && wb.adr == MTIMER_MTIME_HI)
        mtime[63:32] <= merge32(mtime[63:32], wb.dat, wb.sel);
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr && wb.adr == MTIMER_CMP_LO)
        mtimecmp[31:0]  <= merge32(mtimecmp[31:0], wb.dat, wb.sel);
      if (wr && wb.adr == MTIMER_CMP_HI)
        mtimecmp[63:32] <= merge32(mtimecmp[63:32], wb.dat, wb.sel);

      // Low read snapshots the high half so a lo-then-hi pair is carry-safe.
      if (rd) begin
        case (wb.adr)
          MTIMER_MTIME_LO: begin
            rdt_q     <= mtime[31:0];
            hi_shadow <= mtime[63:32];
          end
          MTIMER_MTIME_HI: rdt_q <= hi_shadow;
          MTIMER_CMP_LO:   rdt_q <= mtimecmp[31:0];
          MTIMER_CMP_HI:   rdt_q <= mtimecmp[63:32];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servant_mtimer.sv
// Directed bench: three timers (DIV=1/halt-stop, DIV=4, DIV=1/no-stop) on one shared bus.
module tb_servant_mtimer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        cyc = 1'b0, we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = 4'hF;
  logic        mtip_m, mtip_4, mtip_n;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [31:0] rm, r4, rn;

  servant_mtimer_if bm ();
  servant_mtimer_if b4 ();
  servant_mtimer_if bn ();

  assign bm.cyc = cyc; assign bm.we = we; assign bm.adr = adr; assign bm.dat = dat; assign bm.sel = sel;
  assign b4.cyc = cyc; assign b4.we = we; assign b4.adr = adr; assign b4.dat = dat; assign b4.sel = sel;
  assign bn.cyc = cyc; assign bn.we = we; assign bn.adr = adr; assign bn.dat = dat; assign bn.sel = sel;

  servant_mtimer #(.DIV(1), .DBG_STOP(1'b1)) dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_dbg_halt(halt), .wb(bm.slave), .o_mtip(mtip_m));
  servant_mtimer #(.DIV(4), .DBG_STOP(1'b1)) dut_4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dbg_halt(halt), .wb(b4.slave), .o_mtip(mtip_4));
  servant_mtimer #(.DIV(1), .DBG_STOP(1'b0)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_dbg_halt(halt), .wb(bn.slave), .o_mtip(mtip_n));

  always #5 clk = ~clk;

  // Bench time base: rising edges since the last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance (on negedges) so the next transaction is sampled at edge e.
  task automatic goto(input int e);
    chk("goto_schedule", 32'(edge_cnt <= e - 1), 32'd1);
    while (edge_cnt < e - 1) @(negedge clk);
  endtask

  // One transfer: drive at a negedge, sample ack/rdt at the next negedge, drop cyc.
  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(negedge clk);
    chk("ack_m", 32'(bm.ack), 32'd1);
    chk("ack_4", 32'(b4.ack), 32'd1);
    rm = bm.rdt; r4 = b4.rdt; rn = bn.rdt;
    cyc = 1'b0; we = 1'b0;
  endtask

  initial begin
    // ---- reset defaults ----
    repeat (3) @(negedge clk);
    chk("rst_ack",  32'(bm.ack), 32'd0);
    chk("rst_rdt",  bm.rdt,      32'd0);
    chk("rst_mtip", 32'(mtip_m), 32'd0);
    rst_n = 1'b1;

    // ---- prescale phase and rate (DIV=4) ----
    goto(4);   xfer(1'b0, 2'd0, '0, 4'hF);
    chk("pre_e4_m", rm, 32'd3);
    chk("pre_e4_4", r4, 32'd0);
    goto(9);   xfer(1'b0, 2'd0, '0, 4'hF);
    chk("pre_e9_m", rm, 32'd8);
    chk("pre_e9_4", r4, 32'd2);
    goto(49);  xfer(1'b0, 2'd0, '0, 4'hF);
    chk("pre_40clk_4", r4 - 32'd2, 32'd10);

    // ---- idle count after 100 clocks ----
    goto(101);
    chk("idle_mtip", 32'(mtip_m), 32'd0);
    xfer(1'b0, 2'd0, '0, 4'hF);
    chk("idle_lo_m", rm, 32'd100);
    chk("idle_lo_4", r4, 32'd25);
    goto(103); xfer(1'b0, 2'd1, '0, 4'hF);
    chk("idle_hi_m", rm, 32'd0);
    goto(105); xfer(1'b0, 2'd3, '0, 4'hF);
    chk("rst_cmphi", rm, 32'hFFFF_FFFF);

    // ---- debug freeze: 20 halted edges ----
    goto(107); halt = 1'b1;
    repeat (20) @(negedge clk);
    halt = 1'b0;
    goto(131); xfer(1'b0, 2'd0, '0, 4'hF);
    chk("frz_m",  rm, 32'd110);
    chk("frz_n",  rn, 32'd130);
    chk("frz_4",  r4, 32'd27);

    // ---- interrupt assert ----
    goto(141); xfer(1'b1, 2'd0, 32'd0,  4'hF);
    goto(143); xfer(1'b1, 2'd3, 32'd0,  4'hF);
    goto(145); xfer(1'b1, 2'd2, 32'd50, 4'hF);
    while (edge_cnt < 191) @(negedge clk);
    chk("irq_before", 32'(mtip_m), 32'd0);
    @(negedge clk);
    chk("irq_rise",   32'(mtip_m), 32'd1);

    // ---- interrupt clear via mtimecmp write ----
    goto(195); xfer(1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF);
    chk("clr_at_ack", 32'(mtip_m), 32'd1);
    @(negedge clk);
    chk("clr_fall",   32'(mtip_m), 32'd0);
    goto(199); xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF);

    // ---- atomic lo/hi read across a carry ----
    goto(201); xfer(1'b1, 2'd1, 32'd0, 4'hF);
    goto(203); xfer(1'b1, 2'd0, 32'hFFFF_FFFE, 4'hF);
    goto(205); xfer(1'b0, 2'd0, '0, 4'hF);
    chk("carry_lo", rm, 32'hFFFF_FFFF);
    goto(207); xfer(1'b0, 2'd1, '0, 4'hF);
    chk("carry_hi", rm, 32'd0);
    goto(209); xfer(1'b0, 2'd0, '0, 4'hF);
    chk("post_lo", rm, 32'd3);
    goto(211); xfer(1'b0, 2'd1, '0, 4'hF);
    chk("post_hi", rm, 32'd1);

    // ---- write/tick collision with partial byte enables ----
    goto(213); xfer(1'b1, 2'd0, 32'hAABB_CCDD, 4'hF);
    goto(215); xfer(1'b1, 2'd0, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    chk("ack_pulse", 32'(bm.ack), 32'd0);
    xfer(1'b0, 2'd0, '0, 4'hF);
    chk("merge_lo", rm, 32'hAABB_5679);
    goto(219); xfer(1'b0, 2'd1, '0, 4'hF);
    chk("merge_hi", rm, 32'd1);

    // ---- continuous cyc: alternating ack ----
    goto(221);
    cyc = 1'b1; we = 1'b0; adr = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("alt_ack", 32'(bm.ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("alt_rdt", bm.rdt, 32'hFFFF_FFFF);
    end
    cyc = 1'b0;

    // ---- reset in the middle of a transfer ----
    goto(229);
    cyc = 1'b1; adr = 2'd0;
    @(negedge clk);
    chk("mid_ack_pre", 32'(bm.ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack",  32'(bm.ack), 32'd0);
    chk("mid_rdt",  bm.rdt,      32'd0);
    chk("mid_mtip", 32'(mtip_m), 32'd0);
    cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    goto(3); xfer(1'b0, 2'd2, '0, 4'hF);
    chk("rerst_cmplo", rm, 32'hFFFF_FFFF);
    goto(5); xfer(1'b0, 2'd0, '0, 4'hF);
    chk("rerst_lo_m", rm, 32'd4);
    chk("rerst_lo_4", r4, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
